// File: rtl/riscv_lite_pkg.sv
// Shared RISC-V-lite decode types: opcodes, ALU control codes, immediate formats
// and the ID/EX pipeline bundle.
package riscv_lite_pkg;

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcBranch = 7'b1100011;

  localparam logic [6:0] F7Zero = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;

  typedef enum logic [3:0] {
    AluAdd  = 4'b0000,
    AluSll  = 4'b0001,
    AluSra  = 4'b0010,
    AluSub  = 4'b0011,
    AluXor  = 4'b0100,
    AluLink = 4'b0101,
    AluPass = 4'b0110,
    AluBle  = 4'b0111,
    AluBne  = 4'b1000
  } alu_ctrl_t;

  typedef enum logic [2:0] {
    ImmNone,
    ImmI,
    ImmS,
    ImmB,
    ImmU,
    ImmJ,
    ImmShamt
  } imm_type_t;

  typedef struct packed {
    logic [31:0] pc;
    alu_ctrl_t   alu_ctrl;
    logic        op1_sel;
    logic        op2_sel;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_we;
    logic        mem_rd;
    logic        mem_wr;
    logic        branch;
    logic        jump;
  } id_ex_t;

endpackage

// File: rtl/id_imm_gen.sv
// Combinational immediate extractor/sign-extender for the I/S/B/U/J formats and
// zero-extended shift amounts. The opcode bits are not needed here.
module id_imm_gen
  import riscv_lite_pkg::*;
(
  input  logic [31:7] i_instr,
  input  imm_type_t   i_imm_type,
  output logic [31:0] o_imm
);

  always_comb begin
    o_imm = 32'd0;
    case (i_imm_type)
      ImmI:     o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
      ImmS:     o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      ImmB:     o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                         i_instr[11:8], 1'b0};
      ImmU:     o_imm = {i_instr[31:12], 12'd0};
      ImmJ:     o_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                         i_instr[30:21], 1'b0};
      ImmShamt: o_imm = {27'd0, i_instr[24:20]};
      default:  o_imm = 32'd0;
    endcase
  end

endmodule

// File: rtl/id_stage_decoder.sv
// ID stage: decodes one instruction per cycle into a registered ID/EX bundle with
// load-use bubbling and flush. Define ID_ILLEGAL_CHECK_EN for full funct checking.
module id_stage_decoder
  import riscv_lite_pkg::*;
#(
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   flush_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [31:0]            instr_i,
  input  logic [31:0]            pc_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [31:0]            pc_o,
  output logic [3:0]             alu_ctrl_o,
  output logic                   op1_sel_o,
  output logic                   op2_sel_o,
  output logic [31:0]            imm_o,
  output logic [4:0]             rs1_o,
  output logic [4:0]             rs2_o,
  output logic [4:0]             rd_o,
  output logic                   reg_we_o,
  output logic                   mem_rd_o,
  output logic                   mem_wr_o,
  output logic                   branch_o,
  output logic                   jump_o,
  output logic                   illegal_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

`ifdef ID_ILLEGAL_CHECK_EN
  localparam logic IllegalCheck = 1'b1;
`else
  localparam logic IllegalCheck = 1'b0;
`endif
  localparam logic [STALL_CNT_W-1:0] CntOne = 1;

  logic [6:0]  w_opcode, w_funct7;
  logic [2:0]  w_funct3;
  logic [4:0]  w_rs1, w_rs2, w_rd;
  logic        w_known, w_funct_ok, w_illegal, w_nop;
  logic        w_uses_rs1, w_uses_rs2;
  logic        w_load, w_hazard, w_accept, w_stall;
  imm_type_t   w_imm_type;
  logic [31:0] w_imm;
  id_ex_t      w_dec, w_bundle;

  id_ex_t                 r_bundle;
  logic                   r_valid, r_illegal;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  assign w_opcode = instr_i[6:0];
  assign w_funct3 = instr_i[14:12];
  assign w_funct7 = instr_i[31:25];
  assign w_rs1    = instr_i[19:15];
  assign w_rs2    = instr_i[24:20];
  assign w_rd     = instr_i[11:7];

  id_imm_gen u_imm_gen (
    .i_instr    (instr_i[31:7]),
    .i_imm_type (w_imm_type),
    .o_imm      (w_imm)
  );

  // Unsupported funct fields fall through to the base op of the opcode.
  always_comb begin
    w_dec          = '0;
    w_dec.pc       = pc_i;
    w_dec.alu_ctrl = AluAdd;
    w_imm_type     = ImmNone;
    w_known        = 1'b1;
    w_funct_ok     = 1'b1;
    w_uses_rs1     = 1'b0;
    w_uses_rs2     = 1'b0;
    case (w_opcode)
      OpcOp: begin
        w_uses_rs1   = 1'b1;
        w_uses_rs2   = 1'b1;
        w_dec.reg_we = 1'b1;
        if (w_funct3 == 3'b000 && w_funct7 == F7Alt) w_dec.alu_ctrl = AluSub;
        else if (w_funct3 == 3'b100 && w_funct7 == F7Zero) w_dec.alu_ctrl = AluXor;
        else w_funct_ok = (w_funct3 == 3'b000) && (w_funct7 == F7Zero);
      end
      OpcOpImm: begin
        w_uses_rs1    = 1'b1;
        w_dec.reg_we  = 1'b1;
        w_dec.op2_sel = 1'b1;
        w_imm_type    = ImmI;
        if (w_funct3 == 3'b001 && w_funct7 == F7Zero) begin
          w_dec.alu_ctrl = AluSll;
          w_imm_type     = ImmShamt;
        end else if (w_funct3 == 3'b101 && w_funct7 == F7Alt) begin
          w_dec.alu_ctrl = AluSra;
          w_imm_type     = ImmShamt;
        end else begin
          w_funct_ok = (w_funct3 == 3'b000);
        end
      end
      OpcLui: begin
        w_dec.reg_we   = 1'b1;
        w_dec.op2_sel  = 1'b1;
        w_dec.alu_ctrl = AluPass;
        w_imm_type     = ImmU;
      end
      OpcLoad: begin
        w_uses_rs1    = 1'b1;
        w_dec.reg_we  = 1'b1;
        w_dec.mem_rd  = 1'b1;
        w_dec.op2_sel = 1'b1;
        w_imm_type    = ImmI;
        w_funct_ok    = (w_funct3 == 3'b010);
      end
      OpcStore: begin
        w_uses_rs1    = 1'b1;
        w_uses_rs2    = 1'b1;
        w_dec.mem_wr  = 1'b1;
        w_dec.op2_sel = 1'b1;
        w_imm_type    = ImmS;
        w_funct_ok    = (w_funct3 == 3'b010);
      end
      OpcJal: begin
        w_dec.reg_we   = 1'b1;
        w_dec.jump     = 1'b1;
        w_dec.op1_sel  = 1'b1;
        w_dec.alu_ctrl = AluLink;
        w_imm_type     = ImmJ;
      end
      OpcJalr: begin
        w_uses_rs1     = 1'b1;
        w_dec.reg_we   = 1'b1;
        w_dec.jump     = 1'b1;
        w_dec.op1_sel  = 1'b1;
        w_dec.alu_ctrl = AluLink;
        w_imm_type     = ImmI;
        w_funct_ok     = (w_funct3 == 3'b000);
      end
      OpcBranch: begin
        w_uses_rs1     = 1'b1;
        w_uses_rs2     = 1'b1;
        w_dec.branch   = 1'b1;
        w_imm_type     = ImmB;
        w_dec.alu_ctrl = (w_funct3 == 3'b001) ? AluBne : AluBle;
        w_funct_ok     = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);
      end
      default: w_known = 1'b0;
    endcase
    w_dec.rs1    = w_uses_rs1 ? w_rs1 : 5'd0;
    w_dec.rs2    = w_uses_rs2 ? w_rs2 : 5'd0;
    w_dec.rd     = w_dec.reg_we ? w_rd : 5'd0;
    w_dec.reg_we = w_dec.reg_we & (w_rd != 5'd0);
  end

  assign w_illegal = IllegalCheck & (~w_known | ~w_funct_ok);
  assign w_nop     = ~w_known | w_illegal;

  always_comb begin
    w_bundle     = w_dec;
    w_bundle.imm = w_imm;
    if (w_nop) begin
      w_bundle    = '0;
      w_bundle.pc = pc_i;
    end
  end

  assign w_load   = ~r_valid | out_ready_i;
  assign w_hazard = r_valid & r_bundle.mem_rd & (r_bundle.rd != 5'd0) & in_valid_i &
                    ((w_uses_rs1 & (w_rs1 == r_bundle.rd)) |
                     (w_uses_rs2 & (w_rs2 == r_bundle.rd)));
  // A flush drains IF unconditionally so the wrong-path instruction is discarded.
  assign in_ready_o = flush_i | (w_load & ~w_hazard);
  assign w_accept   = ~flush_i & w_load & ~w_hazard & in_valid_i;
  assign w_stall    = ~flush_i & w_load & w_hazard;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_valid     <= 1'b0;
      r_bundle    <= '0;
      r_illegal   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_illegal <= w_accept & w_illegal;
      if (flush_i) begin
        r_valid <= 1'b0;
      end else if (w_load) begin
        r_valid <= w_accept;
        if (w_accept) r_bundle <= w_bundle;
      end
      if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CntOne;
    end
  end

  assign out_valid_o = r_valid;
  assign pc_o        = r_bundle.pc;
  assign alu_ctrl_o  = r_bundle.alu_ctrl;
  assign op1_sel_o   = r_bundle.op1_sel;
  assign op2_sel_o   = r_bundle.op2_sel;
  assign imm_o       = r_bundle.imm;
  assign rs1_o       = r_bundle.rs1;
  assign rs2_o       = r_bundle.rs2;
  assign rd_o        = r_bundle.rd;
  assign reg_we_o    = r_bundle.reg_we;
  assign mem_rd_o    = r_bundle.mem_rd;
  assign mem_wr_o    = r_bundle.mem_wr;
  assign branch_o    = r_bundle.branch;
  assign jump_o      = r_bundle.jump;
  assign illegal_o   = r_illegal;
  assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_id_stage_decoder.sv
// Scoreboard bench for id_stage_decoder: directed known-answer cases, then random
// traffic checked against an instruction-level reference model.
module tb_id_stage_decoder;

`ifdef ID_ILLEGAL_CHECK_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  alu;
    logic        op1, op2;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic        we, mrd, mwr, br, jmp, ill;
  } exp_t;

  logic        clk_i = 1'b0, rst_n_i, flush_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i;
  logic [31:0] instr_i, pc_i, pc_o, imm_o;
  logic [3:0]  alu_ctrl_o;
  logic        op1_sel_o, op2_sel_o, reg_we_o, mem_rd_o, mem_wr_o, branch_o, jump_o, illegal_o;
  logic [4:0]  rs1_o, rs2_o, rd_o;
  logic [15:0] stall_cnt_o;

  id_stage_decoder #(.STALL_CNT_W(16)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .instr_i(instr_i), .pc_i(pc_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .pc_o(pc_o), .alu_ctrl_o(alu_ctrl_o), .op1_sel_o(op1_sel_o),
    .op2_sel_o(op2_sel_o), .imm_o(imm_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o),
    .reg_we_o(reg_we_o), .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o), .branch_o(branch_o),
    .jump_o(jump_o), .illegal_o(illegal_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int          n_tests = 0, n_fail = 0;
  exp_t        exp_q[$];
  bit          mdl_valid;
  exp_t        mdl_b;
  logic [15:0] mdl_stall;
  logic [31:0] pc_cnt = 32'h1000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit reads_rs1(input logic [6:0] opc);
    return opc inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h67, 7'h63};
  endfunction
  function automatic bit reads_rs2(input logic [6:0] opc);
    return opc inside {7'h33, 7'h23, 7'h63};
  endfunction

  // Reference decode straight from the instruction-set rules.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    logic [6:0] opc = ins[6:0], f7 = ins[31:25];
    logic [2:0] f3 = ins[14:12];
    logic [31:0] iimm = {{20{ins[31]}}, ins[31:20]};
    logic [31:0] simm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    logic [31:0] bimm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    logic [31:0] uimm = {ins[31:12], 12'd0};
    logic [31:0] jimm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    logic [31:0] sh   = {27'd0, ins[24:20]};
    bit ok = 1'b1, known = 1'b1;
    e = '0;
    case (opc)
      7'h33: begin
        e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7]; e.we = 1;
        if (f3 == 0 && f7 == 7'h00) e.alu = 4'd0;
        else if (f3 == 0 && f7 == 7'h20) e.alu = 4'd3;
        else if (f3 == 4 && f7 == 7'h00) e.alu = 4'd4;
        else ok = 0;
      end
      7'h13: begin
        e.rs1 = ins[19:15]; e.rd = ins[11:7]; e.we = 1; e.op2 = 1; e.imm = iimm;
        if (f3 == 1 && f7 == 7'h00) begin e.alu = 4'd1; e.imm = sh; end
        else if (f3 == 5 && f7 == 7'h20) begin e.alu = 4'd2; e.imm = sh; end
        else ok = (f3 == 0);
      end
      7'h37: begin e.rd = ins[11:7]; e.we = 1; e.op2 = 1; e.alu = 4'd6; e.imm = uimm; end
      7'h03: begin
        e.rs1 = ins[19:15]; e.rd = ins[11:7]; e.we = 1; e.mrd = 1; e.op2 = 1; e.imm = iimm;
        ok = (f3 == 2);
      end
      7'h23: begin
        e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.mwr = 1; e.op2 = 1; e.imm = simm;
        ok = (f3 == 2);
      end
      7'h6f: begin e.rd = ins[11:7]; e.we = 1; e.jmp = 1; e.op1 = 1; e.alu = 4'd5; e.imm = jimm; end
      7'h67: begin
        e.rs1 = ins[19:15]; e.rd = ins[11:7]; e.we = 1; e.jmp = 1; e.op1 = 1; e.alu = 4'd5;
        e.imm = iimm; ok = (f3 == 0);
      end
      7'h63: begin
        e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.br = 1; e.imm = bimm;
        e.alu = (f3 == 1) ? 4'd8 : 4'd7; ok = (f3 == 1 || f3 == 5);
      end
      default: known = 0;
    endcase
    if (!known || (ChkEn && !ok)) begin
      e = '0;
      e.ill = ChkEn;
    end
    if (e.rd == 0) e.we = 0;
    e.pc = pc;
    return e;
  endfunction

  function automatic bit model_hazard(input bit v, input logic [31:0] ins);
    return mdl_valid && mdl_b.mrd && (mdl_b.rd != 0) && v &&
           ((reads_rs1(ins[6:0]) && ins[19:15] == mdl_b.rd) ||
            (reads_rs2(ins[6:0]) && ins[24:20] == mdl_b.rd));
  endfunction

  // One clock: drive, check ready/valid/stall against the model, then advance the model.
  task automatic cycle(input bit v, input logic [31:0] ins, input bit rdy, input bit fl);
    bit hz;
    in_valid_i = v; instr_i = ins; pc_i = pc_cnt; out_ready_i = rdy; flush_i = fl;
    #1;
    hz = model_hazard(v, ins);
    check("in_ready", in_ready_o, fl | ((!mdl_valid | rdy) & !hz));
    check("out_valid", out_valid_o, mdl_valid);
    check("stall_cnt", stall_cnt_o, mdl_stall);
    @(posedge clk_i);
    if (fl) begin
      if (mdl_valid && !rdy) void'(exp_q.pop_back());
      mdl_valid = 0;
    end else if (!mdl_valid || rdy) begin
      if (hz) begin
        mdl_valid = 0;
        if (mdl_stall != 16'hFFFF) mdl_stall++;
      end else if (v) begin
        mdl_b = model(ins, pc_cnt);
        mdl_valid = 1;
        exp_q.push_back(mdl_b);
      end else begin
        mdl_valid = 0;
      end
    end
    pc_cnt += 4;
    #1;
  endtask

  // Monitor: pops and compares whenever EX takes a bundle; tracks the illegal pulse.
  bit prev_v = 0, prev_f = 0;
  always @(negedge clk_i) begin
    exp_t e;
    logic exp_ill;
    if (!rst_n_i) begin
      prev_v = 0; prev_f = 0;
    end else begin
      exp_ill = 1'b0;
      if (out_valid_o) begin
        if (exp_q.size() == 0) check("unexpected_bundle", 1, 0);
        else if (!prev_v || prev_f) exp_ill = exp_q[0].ill;
      end
      check("illegal_o", illegal_o, exp_ill);
      if (out_valid_o && out_ready_i && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pc", pc_o, e.pc);
        check("alu_ctrl", alu_ctrl_o, e.alu);
        check("op_sel", {op1_sel_o, op2_sel_o}, {e.op1, e.op2});
        check("imm", imm_o, e.imm);
        check("regs", {rs1_o, rs2_o, rd_o}, {e.rs1, e.rs2, e.rd});
        check("flags", {reg_we_o, mem_rd_o, mem_wr_o, branch_o, jump_o},
              {e.we, e.mrd, e.mwr, e.br, e.jmp});
      end
      prev_v = out_valid_o;
      prev_f = out_valid_o && out_ready_i;
    end
  end

  function automatic logic [31:0] gen_instr();
    logic [31:0] r = $urandom;
    logic [4:0] rd = 5'($urandom_range(0, 7)), rs1 = 5'($urandom_range(0, 7));
    logic [4:0] rs2 = 5'($urandom_range(0, 7));
    logic [6:0] opcs[8] = '{7'h33, 7'h13, 7'h37, 7'h03, 7'h23, 7'h6f, 7'h67, 7'h63};
    case ($urandom_range(0, 14))
      0: return {7'h00, rs2, rs1, 3'd0, rd, 7'h33};
      1: return {7'h20, rs2, rs1, 3'd0, rd, 7'h33};
      2: return {7'h00, rs2, rs1, 3'd4, rd, 7'h33};
      3: return {r[11:0], rs1, 3'd0, rd, 7'h13};
      4: return {7'h00, r[4:0], rs1, 3'd1, rd, 7'h13};
      5: return {7'h20, r[4:0], rs1, 3'd5, rd, 7'h13};
      6: return {r[19:0], rd, 7'h37};
      7, 13, 14: return {r[11:0], rs1, 3'd2, rd, 7'h03};
      8: return {r[11:5], rs2, rs1, 3'd2, r[4:0], 7'h23};
      9: return {r[19:0], rd, 7'h6f};
      10: return {r[11:0], rs1, 3'd0, rd, 7'h67};
      11: return {r[31:25], rs2, rs1, r[0] ? 3'd5 : 3'd1, r[11:7], 7'h63};
      default: return r[5] ? r : {r[31:7], opcs[r[2:0]]};
    endcase
  endfunction

  localparam logic [31:0] Addi = 32'h00500093, Srai = 32'h4030D393;
  localparam logic [31:0] Lw = 32'h0000A283, Add6 = 32'h00028333;

  initial begin
    rst_n_i = 0; flush_i = 0; in_valid_i = 0; instr_i = 0; pc_i = 0; out_ready_i = 0;
    mdl_valid = 0; mdl_stall = 0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_valid", out_valid_o, 0);
    check("rst_stall", stall_cnt_o, 0);
    check("rst_illegal", illegal_o, 0);
    check("rst_bundle", {pc_o, alu_ctrl_o, reg_we_o, rd_o}, 0);
    rst_n_i = 1;
    #1;
    check("ready_after_rst", in_ready_o, 1);

    cycle(1, Addi, 1, 0);
    check("addi_alu", alu_ctrl_o, 4'd0);
    check("addi_op2", op2_sel_o, 1);
    check("addi_imm", imm_o, 5);
    check("addi_rd", rd_o, 1);
    check("addi_we", reg_we_o, 1);

    cycle(1, Srai, 1, 0);
    for (int k = 0; k < 3; k++) begin
      check("srai_hold", {alu_ctrl_o, imm_o, rd_o}, {4'd2, 32'd3, 5'd7});
      cycle(1, Addi, 0, 0);
    end
    check("srai_hold", {alu_ctrl_o, imm_o, rd_o}, {4'd2, 32'd3, 5'd7});

    cycle(1, Lw, 1, 0);
    cycle(1, Add6, 1, 0);
    check("bubble_valid", out_valid_o, 0);
    check("bubble_stall", stall_cnt_o, 1);
    cycle(1, Add6, 1, 0);
    check("after_bubble_rd", {out_valid_o, rd_o}, {1'b1, 5'd6});
    cycle(1, Lw, 1, 0);
    cycle(1, Addi, 1, 0);
    check("no_bubble", {out_valid_o, rd_o, stall_cnt_o}, {1'b1, 5'd1, 16'd1});

    cycle(1, Addi, 1, 1);
    check("flush_valid", out_valid_o, 0);
    check("flush_stall", stall_cnt_o, 1);

    cycle(1, 32'hFFFFFFFF, 1, 0);
    check("illegal_pulse", illegal_o, ChkEn);
    check("illegal_nop", {out_valid_o, alu_ctrl_o, reg_we_o, mem_rd_o, mem_wr_o},
          {1'b1, 4'd0, 3'd0});

    cycle(1, Lw, 1, 0);
    cycle(1, Add6, 1, 0);
    cycle(1, Add6, 0, 0);
    rst_n_i = 0;
    #1;
    check("midrst_valid", out_valid_o, 0);
    check("midrst_stall", stall_cnt_o, 0);
    exp_q.delete();
    mdl_valid = 0; mdl_stall = 0;
    @(posedge clk_i);
    #2 rst_n_i = 1;
    cycle(1, Addi, 1, 0);
    check("post_rst_addi", {out_valid_o, alu_ctrl_o, imm_o, rd_o}, {1'b1, 4'd0, 32'd5, 5'd1});

    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 9) < 8, gen_instr(), $urandom_range(0, 9) < 7,
            $urandom_range(0, 19) == 0);
    repeat (3) cycle(0, 32'h0, 1, 0);
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_stage_decoder.md
Name: id_stage_decoder

Overview:
Instruction-decode stage of the RISC-V-lite pipeline; it produces the 4-bit ALU control code, operands and selects that the execute-stage ALU consumes.
- Accepts one 32-bit instruction per cycle from IF over a valid/ready handshake.
- Decodes it into a registered ID/EX bundle presented to EX over a valid/ready handshake.
- Inserts a one-cycle load-use bubble and honours branch/jump flushes.

Parameters:
STALL_CNT_W, 16, width of the saturating load-use stall counter

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  asynchronous reset, active low
flush_i  in  1  taken branch/jump resolved in EX; kill ID contents
in_valid_i  in  1  instruction from IF valid
in_ready_o  out  1  ID accepts instruction this cycle
instr_i  in  32  instruction word
pc_i  in  32  PC of instr_i
out_valid_o  out  1  ID/EX bundle valid
out_ready_i  in  1  EX accepts bundle
pc_o  out  32  registered PC
alu_ctrl_o  out  4  ALU code: 0000 add, 0001 sll, 0010 sra, 0011 sub, 0100 xor, 0101 link (op1+4), 0110 pass op2, 0111 ble, 1000 bne
op1_sel_o  out  1  0=rs1, 1=pc
op2_sel_o  out  1  0=rs2, 1=imm
imm_o  out  32  sign-extended immediate (I/S/B/U/J per opcode)
rs1_o, rs2_o, rd_o  out  5 each  register addresses
reg_we_o, mem_rd_o, mem_wr_o, branch_o, jump_o  out  1 each  control flags
illegal_o  out  1  one-cycle pulse on illegal instruction accepted
stall_cnt_o  out  STALL_CNT_W  load-use bubbles inserted, saturating

Behaviour:
- Reset (async, rst_n_i=0):
  - all outputs 0, including out_valid_o, stall_cnt_o and illegal_o.
  - in_ready_o stays combinational; it is 1 once the reset is released.
- Latency: one cycle. Instruction accepted at edge N is on the outputs after edge N.
- Output register loads when out_valid_o=0 or out_ready_i=1.
  - in_ready_o = (~out_valid_o | out_ready_i) & ~hazard.
  - The bundle holds stable while out_valid_o=1 and out_ready_i=0.
- hazard condition (all must hold):
  - out_valid_o=1, mem_rd_o=1 and rd_o!=0;
  - in_valid_i=1;
  - the incoming instruction reads rd_o as rs1, or as rs2 (R/S/B types only).
- On hazard with out_ready_i=1:
  - the output register loads a bubble (out_valid_o=0);
  - the instruction stays in IF;
  - stall_cnt_o increments, saturating at all-ones.
- flush_i has priority over hazard, handshake and illegal detection:
  - next cycle out_valid_o=0;
  - in_ready_o=1 and any presented instruction is consumed and discarded;
  - no illegal_o, no stall count.
- Decode (op1/op2 default rs1/rs2):
  - add → 0000; sub (f7=0100000) → 0011; xor → 0100.
  - addi (li/mv) → 0000 imm.
  - slli (f7=0) → 0001, imm=shamt; srai (f7=0100000) → 0010, imm=shamt.
  - lui → 0110 imm.
  - lw → 0000 imm, mem_rd, reg_we; sw → 0000 imm-S, mem_wr.
  - jal → 0101 op1=pc, jump, reg_we; jalr → 0101 op1=pc, jump, reg_we, imm-I.
  - bge (ble) → 0111 branch; bne → 1000 branch.
- reg_we_o is forced 0 when rd=0.
- Illegal (any other opcode/funct):
  - decoded as a NOP bubble: out_valid_o=1, all write/mem/branch flags 0, alu_ctrl 0000;
  - illegal_o=1 for that one output cycle.

Optional Feature:
ID_ILLEGAL_CHECK_EN
- Defined: full funct3/funct7 checking as in Behaviour; illegal_o pulses.
- Undefined:
  - only the opcode is checked; unsupported funct fields decode as the base op of that opcode (e.g. any OP → add);
  - unknown opcodes become a NOP;
  - illegal_o is tied 0.

Decomposition:
- Package riscv_lite_pkg:
  - opcode constants;
  - alu_ctrl_t enum with the nine codes above, shared with the ALU;
  - imm_type_t;
  - a packed id_ex_t struct.
- One natural sub-module: id_imm_gen, a combinational immediate extractor/sign-extender.

Test Plan:
- Reset: rst_n_i=0 mid-stream with out_valid_o=1 → out_valid_o=0 and stall_cnt_o=0 immediately; first instruction after release decodes normally.
- 0x00500093 (addi x1,x0,5) → alu_ctrl 0000, op2_sel=1, imm=5, rd=1, reg_we=1 one cycle later.
- 0x4030D393 (srai x7,x1,3) → alu_ctrl 0010, imm=3, rd=7; with out_ready_i=0 for 3 cycles the bundle holds and in_ready_o=0.
- Load-use: 0x0000A283 (lw x5) then 0x00028333 (add x6,x5,x0) with out_ready_i=1:
  - one cycle with out_valid_o=0 between the two bundles;
  - stall_cnt_o=1;
  - no bubble if the second instruction is 0x00500093.
- Flush: flush_i=1 while an instruction is presented → instruction consumed and dropped, out_valid_o=0 next cycle, stall_cnt_o unchanged.
- Illegal 0xFFFFFFFF:
  - with ID_ILLEGAL_CHECK_EN → NOP bundle, illegal_o=1 for one cycle;
  - without ID_ILLEGAL_CHECK_EN → NOP bundle, illegal_o=0.
